// File: rtl/aes_pkg.sv
// Shared AES datapath types: block layout, block size and the serializer
// FSM encoding.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [15:0][7:0] aes_block_t;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  // Byte index of the final byte of a block, sized for the 4-bit counter.
  localparam logic [3:0] SER_CNT_LAST = 4'(AES_BLOCK_BYTES - 1);

endpackage

// File: rtl/mod_blkbuf.sv
// One-block holding register with a full flag.
// load captures a block and sets full; take clears full.
// If both strobes are high together, load wins.
module mod_blkbuf
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  aes_block_t load_data,
  input  logic       take,
  output aes_block_t data,
  output logic       full
);

  // Data and occupancy register; cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (load) begin
        data <= load_data;
      end
      if (load) begin
        full <= 1'b1;
      end else if (take) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mod_ser16_16to1.sv
// Block-to-byte serializer: takes one 16-byte AES state per handshake and
// emits it byte 0 first on a byte stream.
// Optional macro AES_SER_DBUF_EN adds a one-block buffer (mod_blkbuf).
// With the buffer, a following block is held ready so blocks stream out
// with no idle cycle between them.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Once out_valid is high, out_valid and out_data stay stable until that
// transfer happens. in_ready depends only on registered state. No
// handshake input reaches an output combinationally.
module mod_ser16_16to1
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_block_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output ser_state_t dbg_state
);

  localparam int N = AES_BLOCK_BYTES;

  ser_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  aes_block_t sreg, sreg_nxt;

  logic accept;
  logic xfer;
  logic final_xfer;
  logic dbuf_full;

`ifdef AES_SER_DBUF_EN
  aes_block_t dbuf_data;
  logic       dbuf_load;
  logic       dbuf_take;

  mod_blkbuf u_dbuf (
    .clk       (clk),
    .resetn    (resetn),
    .load      (dbuf_load),
    .load_data (in_data),
    .take      (dbuf_take),
    .data      (dbuf_data),
    .full      (dbuf_full)
  );

  assign in_ready = !dbuf_full;
`else
  assign dbuf_full = 1'b0;
  assign in_ready  = (state == SER_IDLE);
`endif

  assign out_valid  = (state == SER_SHIFT);
  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign final_xfer = xfer && (cnt == SER_CNT_LAST);

  assign out_data  = sreg[cnt];
  assign out_last  = (state == SER_SHIFT) && (cnt == SER_CNT_LAST);
  assign busy      = (state == SER_SHIFT) || dbuf_full;
  assign dbg_state = state;

  // Next state: load a block on accept, advance per byte, and reload or
  // go idle after the final byte.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
`ifdef AES_SER_DBUF_EN
    dbuf_load = 1'b0;
    dbuf_take = 1'b0;
`endif
    case (state)
      SER_IDLE: begin
        if (accept) begin
          sreg_nxt  = in_data;
          cnt_nxt   = 4'd0;
          state_nxt = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (xfer && (cnt != SER_CNT_LAST)) begin
          cnt_nxt = cnt + 4'd1;
        end else if (final_xfer) begin
          cnt_nxt = 4'd0;
`ifdef AES_SER_DBUF_EN
          if (dbuf_full) begin
            sreg_nxt  = dbuf_data;
            dbuf_take = 1'b1;
          end else
`endif
          if (accept) begin
            // A block arriving on the final-byte edge goes straight
            // into sreg.
            sreg_nxt = in_data;
          end else begin
            state_nxt = SER_IDLE;
          end
        end
`ifdef AES_SER_DBUF_EN
        if (accept && !final_xfer) begin
          dbuf_load = 1'b1;
        end
`endif
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  // State, counter and shift register; reset discards any partial block.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SER_IDLE;
      cnt   <= 4'd0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
    end
  end

endmodule

// File: tb/tb_mod_ser16_16to1.sv
// Directed bench for mod_ser16_16to1, default or AES_SER_DBUF_EN build.
`timescale 1ns/1ps
module tb_mod_ser16_16to1;
  import aes_pkg::*;

`ifdef AES_SER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  aes_block_t in_data = '0;
  logic       in_ready, out_valid, out_last, busy;
  logic [7:0] out_data;
  ser_state_t dbg_state;

  always #5 clk = ~clk;

  mod_ser16_16to1 dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         passed = 0;
  logic [8:0] exp_q[$];            // {last, byte}
  aes_block_t blk[0:3];
  int         acc_cyc[0:3];
  int         t_af, t_b0, first_last_cyc;
  bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic aes_block_t mk(input logic [7:0] base);
    aes_block_t r;
    for (int i = 0; i < 16; i++) r[i] = base + 8'(i);
    return r;
  endfunction

  task automatic push_block(input int idx);
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), blk[idx][i]});
  endtask

  // ---------------- driver ----------------
  // Drives blocks blk[first..last_i] and checks every output byte against exp_q.
  // A block is presented `delay` cycles after the previous accept.
  task automatic run(input int first, input int last_i, input int delay,
                     input bit stall, input int max_cyc);
    int         cyc = 0;
    int         nxt = first;
    int         last_acc = -1000;
    bit         stalled = 1'b0;
    bit         acc;
    logic [7:0] prev = 8'h00;
    logic [8:0] e;
    first_last_cyc = -1;
    while ((nxt <= last_i || exp_q.size() != 0) && cyc < max_cyc) begin
      out_ready = stall ? pat[cyc % 4] : 1'b1;
      in_valid  = (nxt <= last_i) && (cyc >= last_acc + delay);
      if (nxt <= last_i) in_data = blk[nxt];
      acc = in_valid && in_ready;
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'(out_data), 32'(e[7:0]));
          check("last", 32'(out_last), 32'(e[8]));
        end
        if (out_data == 8'hAF) t_af = cyc;
        if (out_data == 8'hB0) t_b0 = cyc;
        if (out_last && first_last_cyc < 0) first_last_cyc = cyc;
      end
      stalled = out_valid && !out_ready;
      prev    = out_data;
      if (acc) begin
        push_block(nxt);
        acc_cyc[nxt] = cyc;
        last_acc     = cyc;
        nxt++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("drained", 32'(exp_q.size()), 32'd0);
    check("all_sent", 32'(nxt), 32'(last_i + 1));
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    step();

    // Single block 00..0F, byte j transfers on edge k+1+j
    blk[0]    = mk(8'h00);
    in_data   = blk[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("sb_in_ready", 32'(in_ready), 32'd1);
    step();                                   // edge k: accept
    in_valid = 1'b0;
    check("sb_lat_valid", 32'(out_valid), 32'd1);
    check("sb_busy", 32'(busy), 32'd1);
    check("sb_in_ready_shift", 32'(in_ready), 32'(DBUF));
    for (int j = 0; j < 16; j++) begin
      check("sb_byte", 32'(out_data), 32'(j));
      check("sb_last", 32'(out_last), 32'(j == 15));
      step();
    end
    check("sb_done_valid", 32'(out_valid), 32'd0);
    check("sb_done_busy", 32'(busy), 32'd0);

    // Backpressure with out_ready pattern 1,0,0,1
    blk[0] = mk(8'h20);
    run(0, 0, 1, 1'b1, 200);

    // Back-to-back A then B, presented right after A is accepted
    blk[0] = mk(8'hA0);
    blk[1] = mk(8'hB0);
    t_af = -1;
    t_b0 = -1;
    run(0, 1, 1, 1'b0, 100);
    check("b2b_gap", 32'(t_b0 - t_af), DBUF ? 32'd1 : 32'd2);

    // B presented on the cycle A's byte 15 transfers (bypass edge)
    t_af = -1;
    t_b0 = -1;
    run(0, 1, 16, 1'b0, 100);
    check("byp_gap", 32'(t_b0 - t_af), DBUF ? 32'd1 : 32'd2);
    check("byp_acc", 32'(acc_cyc[1] - acc_cyc[0]), DBUF ? 32'd16 : 32'd17);

`ifdef AES_SER_DBUF_EN
    // Buffer full: three blocks with out_ready low
    blk[0]    = mk(8'hC0);
    blk[1]    = mk(8'hD0);
    blk[2]    = mk(8'hE0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = blk[0];
    step();
    check("bf_rdy_after1", 32'(in_ready), 32'd1);
    in_data = blk[1];
    step();
    check("bf_rdy_after2", 32'(in_ready), 32'd0);
    check("bf_busy", 32'(busy), 32'd1);
    push_block(0);
    push_block(1);
    in_data = blk[2];
    for (int i = 0; i < 3; i++) begin
      step();
      check("bf_rdy_hold", 32'(in_ready), 32'd0);
      check("bf_data_hold", 32'(out_data), 32'hC0);
    end
    run(2, 2, 0, 1'b0, 100);
    check("bf_third_acc", 32'(acc_cyc[2]), 32'(first_last_cyc + 1));
`endif

    // Mid-block reset after byte 5
    exp_q.delete();
    blk[0]    = mk(8'h50);
    in_data   = blk[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      check("mr_byte", 32'(out_data), 32'h50 + 32'(j));
      step();
    end
    #2 resetn = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_data", 32'(out_data), 32'd0);
    check("mr_out_last", 32'(out_last), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_state", 32'(dbg_state), 32'(SER_IDLE));
    step();
    resetn = 1'b1;
    step();
    blk[0] = mk(8'h60);
    run(0, 0, 1, 1'b0, 40);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mod_ser16_16to1.md
# mod_ser16_16to1

Block-to-byte serializer for the AES datapath output. It accepts one 128-bit state (16 bytes) per valid/ready handshake from the round pipeline and emits it as 16 byte transfers over a valid/ready byte stream. Byte 0 goes first, matching the byte-0-first order of the input collector, so a block round-trips with the same byte order. It is the output-side counterpart to the 1-to-16 input collector.

## Interface
- N, 16, bytes per block; fixed at 16 for AES, kept only for readability.
- clk  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- in_valid  input  1  upstream block present.
- in_ready  output  1  block can be accepted this cycle.
- in_data  input  [N-1:0][7:0]  block; byte index 0 is sent first.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  8  current byte.
- out_last  output  1  current byte is byte N-1 of its block.
- busy  output  1  a block is being shifted out or is buffered.

## Operation
- Block accept: `in_valid && in_ready` at a rising edge. Byte transfer: `out_valid && out_ready` at a rising edge.
- FSM states:
  - IDLE: out_valid=0.
  - SHIFT: out_valid=1.
- Registers:
  - shift register `sreg[N-1:0][7:0]`.
  - 4-bit byte counter `cnt`.
- Combinational outputs:
  - out_data = sreg[cnt].
  - out_last = (state==SHIFT) && (cnt==N-1).
  - busy = (state==SHIFT) || dbuf_full. dbuf_full is constant 0 when the buffer is compiled out.
- IDLE, block accept: sreg<=in_data, cnt<=0, go to SHIFT.
- SHIFT, byte transfer with cnt<N-1: cnt<=cnt+1.
- SHIFT, byte transfer with cnt==N-1 (counter wraps to 0):
  - next block available (see Configuration): sreg<=next block, cnt<=0, stay in SHIFT.
  - no next block: go to IDLE.
- out_valid without out_ready: out_data, cnt and sreg hold. Once out_valid is high, it stays high until the transfer completes.
- Reset values (asynchronous):
  - state=IDLE, cnt=0, sreg=0, dbuf=0, dbuf_full=0.
  - Outputs: out_valid=0, out_data=8'h00, out_last=0, busy=0, in_ready=1.
- Reset mid-block: all buffered and partially sent data is discarded with no flush. After reset, the first byte out is byte 0 of the next accepted block.
- in_data is sampled only on an accept edge; it is don't-care otherwise.

## Timing
- Latency: block accepted at edge k, so byte 0 is valid in the cycle after edge k. With out_ready held high, byte j transfers at edge k+1+j.
- Throughput with out_ready held high:
  - without buffer: one block per N+1 cycles, with one idle bubble between blocks.
  - with buffer: one block per N cycles, with no bubble.
- in_ready is combinational from registered state only, never from in_valid or out_ready. There is no combinational path from input to output on either handshake.

## Configuration
- Macro: `AES_SER_DBUF_EN`.
- Undefined:
  - in_ready = (state==IDLE).
  - A block can only be accepted in IDLE.
  - On the cnt==N-1 transfer the block always goes to IDLE.
- Defined: adds a one-block buffer `dbuf` plus `dbuf_full`.
  - in_ready = !dbuf_full.
  - Accept in IDLE: load sreg directly; dbuf stays empty.
  - Accept in SHIFT on a non-final edge: dbuf<=in_data, dbuf_full<=1.
  - Final-byte transfer with dbuf_full: sreg<=dbuf, dbuf_full<=0, stay in SHIFT.
  - Final-byte transfer on the same edge as an accept with dbuf empty: bypass, with sreg<=in_data, cnt<=0, stay in SHIFT; dbuf stays empty.
  - Final-byte transfer with dbuf_full and no accept: dbuf_full clears. in_ready=0 in that cycle, so an accept cannot occur on the same edge.

## Structure
- Shared package `aes_pkg`:
  - `AES_BLOCK_BYTES=16`.
  - `typedef logic [15:0][7:0] aes_block_t`.
  - `typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t`.
- Sub-module `mod_blkbuf`: a one-block register holding data plus a full flag, with load and take strobes. It is instantiated only under `AES_SER_DBUF_EN`.
- The FSM, counter and byte mux stay in the top module.

## Test plan
- Reset and single block: after reset, check in_ready=1 and out_valid=0. Send in_data bytes 0..15 = 8'h00..8'h0F with out_ready=1. Expect bytes 00..0F on edges k+1..k+16, out_last only with 8'h0F, and busy=0 afterwards.
- Backpressure: toggle out_ready 1,0,0,1,... Expect out_data held stable while stalled and exactly 16 transfers in order. No byte is duplicated or dropped.
- Back-to-back blocks: send block A=8'hA0..8'hAF, then block B=8'hB0..8'hBF, presented immediately with out_ready=1.
  - Without the macro: one idle cycle between 8'hAF and 8'hB0.
  - With the macro: 8'hB0 on the cycle right after 8'hAF. The bypass-edge case must also be exercised.
- Buffer full (macro defined): send three blocks with out_ready=0. Expect in_ready=0 after the second accept. The third block is accepted only after block 1's byte 15 transfers.
- Mid-block reset: assert resetn=0 asynchronously after byte 5 of a block. Expect out_valid to drop immediately and all outputs to take their reset values. The next block starts again at its byte 0.
